// File: rtl/frame_render_pkg.sv
// Shared constants and types for the frame renderer: VGA 640x480 timing,
// game geometry, colours, the per-frame state snapshot and the pipe hit test.
package frame_render_pkg;

    localparam logic [9:0] H_TOTAL        = 10'd800;
    localparam logic [9:0] H_VISIBLE      = 10'd640;
    localparam logic [9:0] H_SYNC_START   = 10'd656;
    localparam logic [9:0] H_SYNC_END     = 10'd752;
    localparam logic [9:0] H_LAST         = H_TOTAL - 10'd1;
    localparam logic [9:0] H_LAST_VISIBLE = H_VISIBLE - 10'd1;

    localparam logic [9:0] V_TOTAL        = 10'd525;
    localparam logic [9:0] V_VISIBLE      = 10'd480;
    localparam logic [9:0] V_SYNC_START   = 10'd490;
    localparam logic [9:0] V_SYNC_END     = 10'd492;
    localparam logic [9:0] V_LAST         = V_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST_VISIBLE = V_VISIBLE - 10'd1;

    localparam logic [9:0] BIRD_X      = 10'd10;
    localparam logic [9:0] BIRD_SIZE   = 10'd16;
    localparam logic [9:0] BIRD_X_END  = BIRD_X + BIRD_SIZE;
    localparam logic [9:0] PIPE_WIDTH  = 10'd50;
    localparam logic [9:0] PIPE_GAP    = 10'd50;
    localparam logic [9:0] SCORE_ROWS  = 10'd8;

    typedef logic [11:0] rgb_t;

    localparam rgb_t COLOUR_BLANK       = 12'h000;
    localparam rgb_t COLOUR_BIRD        = 12'hFF0;
    localparam rgb_t COLOUR_BIRD_RISING = 12'hF80;
    localparam rgb_t COLOUR_PIPE        = 12'h0C0;
    localparam rgb_t COLOUR_SKY         = 12'h4AF;
    localparam rgb_t COLOUR_FAIL        = 12'h800;
    localparam rgb_t COLOUR_SCORE       = 12'hFFF;

    typedef struct packed {
        logic [15:0] bird_y;
        logic [19:0] pipe1;
        logic [19:0] pipe2;
        logic [19:0] pipe3;
        logic        fail;
        logic [15:0] score;
    } snapshot_t;

    localparam snapshot_t SNAPSHOT_RESET = '{
        bird_y: 16'd240,
        pipe1:  20'd0,
        pipe2:  20'd0,
        pipe3:  20'd0,
        fail:   1'b0,
        score:  16'd0
    };

    // 11-bit sums so that x+width and y+gap never wrap for large pipe values.
    function automatic logic pipe_hit(input logic [9:0] h, input logic [9:0] game_y,
                                      input logic [19:0] pipe);
        logic [10:0] x;
        logic [10:0] y;
        x = {1'b0, pipe[19:10]};
        y = {1'b0, pipe[9:0]};
        return ({1'b0, h} >= x) && ({1'b0, h} < x + {1'b0, PIPE_WIDTH}) &&
               (({1'b0, game_y} < y) || ({1'b0, game_y} >= y + {1'b0, PIPE_GAP}));
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick prescaler and 800x525 raster counters with raw (unregistered)
// active-low syncs and the visible-area flag for the current counter value.
module vga_timing
    import frame_render_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hs_raw,
    output logic       vs_raw,
    output logic       visible
);

    logic [1:0] prescaler;

    assign tick = (prescaler == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= 2'd0;
            hcount    <= 10'd0;
            vcount    <= 10'd0;
        end else begin
            prescaler <= prescaler + 2'd1;
            if (tick) begin
                if (hcount == H_LAST) begin
                    hcount <= 10'd0;
                    vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    assign hs_raw  = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
    assign vs_raw  = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
    assign visible = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);

endmodule

// File: rtl/frame_render.sv
// Renders bird, three pipes and background onto a 640x480 VGA raster from a
// once-per-frame snapshot of game state. Optional score bar: define SCORE_BAR_EN.
module frame_render
    import frame_render_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bird_y,
    input  logic [19:0] pipe1,
    input  logic [19:0] pipe2,
    input  logic [19:0] pipe3,
    input  logic        fail,
    input  logic [15:0] score,
    output logic        hs,
    output logic        vs,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        frame_start
);

    logic       tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hs_raw;
    logic       vs_raw;
    logic       visible;

    vga_timing u_timing (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .hcount  (hcount),
        .vcount  (vcount),
        .hs_raw  (hs_raw),
        .vs_raw  (vs_raw),
        .visible (visible)
    );

    snapshot_t shadow;
    logic      snap;

    // Snapshot at the start of vertical blanking so a whole frame sees one state.
    assign snap = tick && (hcount == 10'd0) && (vcount == V_VISIBLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= SNAPSHOT_RESET;
        end else if (snap) begin
            shadow <= '{bird_y: bird_y, pipe1: pipe1, pipe2: pipe2, pipe3: pipe3,
                        fail: fail, score: score};
        end
    end

    logic [9:0] game_y;
    logic [9:0] bird_bottom;
    logic       bird_hit;
    logic       pipe_any;
    logic       unused_bits;

    assign game_y      = V_LAST_VISIBLE - vcount;
    assign bird_bottom = shadow.bird_y[9:0];
    assign bird_hit    = (hcount >= BIRD_X) && (hcount < BIRD_X_END) &&
                         ({1'b0, game_y} >= {1'b0, bird_bottom}) &&
                         ({1'b0, game_y} < {1'b0, bird_bottom} + {1'b0, BIRD_SIZE});
    assign pipe_any    = pipe_hit(hcount, game_y, shadow.pipe1) ||
                         pipe_hit(hcount, game_y, shadow.pipe2) ||
                         pipe_hit(hcount, game_y, shadow.pipe3);

`ifdef SCORE_BAR_EN
    logic [9:0] bar_end;
    logic       score_hit;

    assign bar_end     = (shadow.score[9:0] > H_LAST_VISIBLE) ? H_LAST_VISIBLE
                                                              : shadow.score[9:0];
    assign score_hit   = (vcount < SCORE_ROWS) && (hcount < bar_end);
    assign unused_bits = ^{shadow.bird_y[14:10], shadow.score[15:10]};
`else
    assign unused_bits = ^{shadow.bird_y[14:10], shadow.score};
`endif

    rgb_t colour;

    always_comb begin
        colour = COLOUR_BLANK;
        if (visible) begin
            if (bird_hit) begin
                colour = shadow.bird_y[15] ? COLOUR_BIRD_RISING : COLOUR_BIRD;
            end else if (pipe_any) begin
                colour = COLOUR_PIPE;
`ifdef SCORE_BAR_EN
            end else if (score_hit) begin
                colour = COLOUR_SCORE;
`endif
            end else begin
                colour = shadow.fail ? COLOUR_FAIL : COLOUR_SKY;
            end
        end
    end

    // Colour and syncs share one tick of latency so they stay aligned at the pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs          <= 1'b1;
            vs          <= 1'b1;
            r           <= 4'd0;
            g           <= 4'd0;
            b           <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= snap;
            if (tick) begin
                hs        <= hs_raw;
                vs        <= vs_raw;
                {r, g, b} <= colour;
            end
        end
    end

endmodule

// File: tb/tb_frame_render.sv
// Directed bench for frame_render: scoreboard of expected pixels checked by a
// raster-position monitor, plus sync timing, snapshot pulse and async reset checks.
`timescale 1ns/1ps
module tb_frame_render;

    localparam int unsigned LINE_PIX  = 800;
    localparam int unsigned FRAME_PIX = 800 * 525;
    localparam int unsigned FRAME_CLK = 4 * FRAME_PIX;
    localparam int unsigned SNAP_CLK  = 4 * (480 * 800 + 1);
    localparam int unsigned RUN_CLK   = 3_262_000;

    // clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] bird_y;
    logic [19:0] pipe1;
    logic [19:0] pipe2;
    logic [19:0] pipe3;
    logic        fail;
    logic [15:0] score;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    logic        frame_start;

    frame_render dut (
        .clk         (clk),
        .rst         (rst),
        .bird_y      (bird_y),
        .pipe1       (pipe1),
        .pipe2       (pipe2),
        .pipe3       (pipe3),
        .fail        (fail),
        .score       (score),
        .hs          (hs),
        .vs          (vs),
        .r           (r),
        .g           (g),
        .b           (b),
        .frame_start (frame_start)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned clk_cnt;
    int unsigned fs_n = 0;
    logic        armed = 1'b0;

    // scoreboard entry: {absolute pixel index since release, expected rgb}
    logic [43:0] exp_q[$];

    // Bench-side position model: clocks since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) clk_cnt <= 0;
        else     clk_cnt <= clk_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pix(input int unsigned frame, input int unsigned h,
                            input int unsigned v, input logic [11:0] rgb);
        logic [31:0] idx;
        idx = 32'(frame * FRAME_PIX + v * LINE_PIX + h);
        exp_q.push_back({idx, rgb});
    endtask

    task automatic wait_clk(input int unsigned target);
        int unsigned guard;
        guard = 0;
        while (clk_cnt != target && guard < RUN_CLK + 100) begin
            @(negedge clk);
            guard++;
        end
        if (clk_cnt != target) check("wait timeout", clk_cnt, target);
    endtask

    // monitor: each tick, the output holds the pixel registered on that tick
    initial begin
        int unsigned p;
        logic [43:0] e;
        forever begin
            @(negedge clk);
            if (armed && !rst && clk_cnt != 0 && (clk_cnt % 4) == 0) begin
                p = clk_cnt / 4 - 1;
                if (exp_q.size() != 0 && exp_q[0][43:12] == p) begin
                    e = exp_q.pop_front();
                    check($sformatf("pixel f%0d h%0d v%0d", p / FRAME_PIX,
                                    p % LINE_PIX, (p % FRAME_PIX) / LINE_PIX),
                          {20'd0, r, g, b}, {20'd0, e[11:0]});
                end
            end
        end
    end

    // sync and frame_start timing monitor
    initial begin
        int unsigned hs_fall = 0;
        int unsigned hs_n = 0;
        int unsigned vs_fall = 0;
        int unsigned vs_n = 0;
        logic hs_prev = 1'b1;
        logic vs_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (armed && !rst) begin
                if (hs_prev && !hs) begin
                    if (hs_n > 0 && hs_n <= 3) check("hs period", clk_cnt - hs_fall, 3200);
                    hs_fall = clk_cnt;
                    hs_n++;
                end
                if (!hs_prev && hs && hs_n <= 3) check("hs low width", clk_cnt - hs_fall, 384);
                if (vs_prev && !vs) begin
                    if (vs_n == 1) check("vs period", clk_cnt - vs_fall, FRAME_CLK);
                    vs_fall = clk_cnt;
                    vs_n++;
                end
                if (!vs_prev && vs) check("vs low width", clk_cnt - vs_fall, 6400);
                if (frame_start) begin
                    fs_n++;
                    check("frame_start position", clk_cnt % FRAME_CLK, SNAP_CLK);
                end
            end
            hs_prev = hs;
            vs_prev = vs;
        end
    end

    // driver
    initial begin
        logic [11:0] bar;
        bird_y = 16'd240;
        pipe1  = {10'd700, 10'd0};
        pipe2  = {10'd700, 10'd0};
        pipe3  = {10'd700, 10'd0};
        fail   = 1'b0;
        score  = 16'd0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset rgb", {20'd0, r, g, b}, 32'd0);
        check("reset hs", {31'd0, hs}, 32'd1);
        check("reset vs", {31'd0, vs}, 32'd1);
        check("reset frame_start", {31'd0, frame_start}, 32'd0);

        // reset mid-line during visible pixels
        rst = 1'b0;
        wait_clk(4 * (2 * 800 + 300 + 1));
        check("sky before reset", {20'd0, r, g, b}, 32'h4AF);
        #1 rst = 1'b1;
        #1 check("rgb cleared by async reset", {20'd0, r, g, b}, 32'd0);
        check("vs high on async reset", {31'd0, vs}, 32'd1);

        // reset during horizontal sync
        @(negedge clk) rst = 1'b0;
        wait_clk(4 * (700 + 1));
        check("hs low in sync", {31'd0, hs}, 32'd0);
        #1 rst = 1'b1;
        #1 check("hs released by async reset", {31'd0, hs}, 32'd1);

        @(negedge clk);
        rst   = 1'b0;
        armed = 1'b1;

        // frame 0 renders reset shadows: bird 240, all pipes {0,0}, fail 0
        push_pix(0, 0,   0,   12'h0C0);
        push_pix(0, 49,  0,   12'h0C0);
        push_pix(0, 50,  0,   12'h4AF);
        push_pix(0, 639, 0,   12'h4AF);
        push_pix(0, 640, 0,   12'h000);
        push_pix(0, 799, 0,   12'h000);
        push_pix(0, 10,  223, 12'h0C0);
        push_pix(0, 9,   224, 12'h0C0);
        push_pix(0, 10,  224, 12'hFF0);
        push_pix(0, 25,  224, 12'hFF0);
        push_pix(0, 26,  224, 12'h0C0);
        push_pix(0, 100, 224, 12'h4AF);
        push_pix(0, 10,  239, 12'hFF0);
        push_pix(0, 10,  240, 12'h0C0);
        push_pix(0, 0,   429, 12'h0C0);
        push_pix(0, 0,   430, 12'h4AF);
        push_pix(0, 100, 479, 12'h4AF);
        push_pix(0, 100, 480, 12'h000);

        // frame 1: bird 100 rising, pipe1 {100,200}, off-screen pipes, fail, score 50
`ifdef SCORE_BAR_EN
        bar = 12'hFFF;
`else
        bar = 12'h800;
`endif
        push_pix(1, 0,   3,   bar);
        push_pix(1, 49,  3,   bar);
        push_pix(1, 50,  3,   12'h800);
        push_pix(1, 0,   8,   12'h800);
        push_pix(1, 639, 100, 12'h800);
        push_pix(1, 700, 100, 12'h000);
        push_pix(1, 120, 229, 12'h0C0);
        push_pix(1, 120, 230, 12'h800);
        push_pix(1, 120, 259, 12'h800);
        push_pix(1, 120, 279, 12'h800);
        push_pix(1, 120, 280, 12'h0C0);
        push_pix(1, 99,  329, 12'h800);
        push_pix(1, 100, 329, 12'h0C0);
        push_pix(1, 120, 329, 12'h0C0);
        push_pix(1, 149, 329, 12'h0C0);
        push_pix(1, 150, 329, 12'h800);
        push_pix(1, 10,  363, 12'h800);
        push_pix(1, 10,  364, 12'hF80);
        push_pix(1, 26,  370, 12'h800);
        push_pix(1, 25,  379, 12'hF80);
        push_pix(1, 10,  380, 12'h800);

        // change game state mid-frame 0; it must only show from frame 1
        wait_clk(4 * (200 * 800 + 1));
        bird_y = 16'h8064;
        pipe1  = {10'd100, 10'd200};
        pipe2  = {10'd700, 10'd10};
        pipe3  = {10'd1023, 10'd0};
        fail   = 1'b1;
        score  = 16'd50;

        wait_clk(RUN_CLK);
        check("frame_start count", fs_n, 2);
        check("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
